// File: rtl/fir_pkg.sv
// fir_pkg: op codes, sequencer states and register indices shared by the FIR control and datapath decode
package fir_pkg;
    localparam int NUM_TAPS = 4;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_COPY  = 3'd1;
    localparam logic [2:0] OP_LOAD1 = 3'd2;
    localparam logic [2:0] OP_LOAD2 = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    // ZERO..SUB4 are contiguous so the straight-line sequence can step by +1
    typedef enum logic [4:0] {
        S_IDLE, S_STORE, S_ZERO,
        S_SORT1, S_SORT2, S_SORT3, S_SORT4,
        S_MUL1, S_ADD1, S_MUL2, S_SUB2, S_MUL3, S_ADD3, S_MUL4, S_SUB4,
        S_LOADC, S_WAITC, S_EIDLE
    } state_t;

    localparam logic [3:0] R0  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle rising-edge pulse on a level input
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic sig_q;

    // remember last cycle's level
    always_ff @(posedge clk)
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;

    assign rise = sig & ~sig_q;
endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: FIR control FSM; FIR_SEQ_OVF_CHECK_EN enables abort to EIDLE on ALU overflow
module fir_sequencer
    import fir_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dr,
    input  logic       lc,
    input  logic       overflow,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       cnt_up,
    output logic       modwait,
    output logic       err
);
    localparam logic [1:0] IDX_LAST = 2'(NUM_TAPS - 1);

    state_t     state, state_n;
    logic [1:0] idx;
    logic       lc_rise;

    edge_detect u_lc_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (lc),
        .rise (lc_rise)
    );

`ifdef FIR_SEQ_OVF_CHECK_EN
    logic alu_state;
    assign alu_state = state inside {S_ZERO, [S_MUL1:S_SUB4]};
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    // next-state: dr beats a simultaneous lc edge in IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = dr ? S_STORE : (lc_rise ? S_LOADC : S_IDLE);
            S_STORE: state_n = dr ? S_ZERO : S_EIDLE;
            S_SUB4:  state_n = S_IDLE;
            S_LOADC: state_n = (idx == IDX_LAST) ? S_IDLE : S_WAITC;
            S_WAITC: state_n = lc_rise ? S_LOADC : S_WAITC;
            S_EIDLE: state_n = dr ? S_STORE : S_EIDLE;
            default: state_n = state_t'(state + 5'd1);
        endcase
`ifdef FIR_SEQ_OVF_CHECK_EN
        if (overflow && alu_state) state_n = S_EIDLE;
`endif
    end

    // state, coefficient index and registered busy flag
    always_ff @(posedge clk)
        if (rst) begin
            state   <= S_IDLE;
            idx     <= 2'd0;
            modwait <= 1'b0;
        end else begin
            state   <= state_n;
            modwait <= !(state_n inside {S_IDLE, S_WAITC, S_EIDLE});
            if (state == S_LOADC) idx <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
        end

    // Moore decode of op and register addresses; unused addresses stay 0
    always_comb begin
        {op, src1, src2, dest} = {OP_NOP, R0, R0, R0};
        cnt_up = (state == S_ZERO);
        err    = (state == S_EIDLE);
        case (state)
            S_STORE: {op, src1, src2, dest} = {OP_LOAD1, R0, R0, R5};
            S_ZERO:  {op, src1, src2, dest} = {OP_SUB,   R0, R0, R0};
            S_SORT1: {op, src1, src2, dest} = {OP_COPY,  R2, R0, R1};
            S_SORT2: {op, src1, src2, dest} = {OP_COPY,  R3, R0, R2};
            S_SORT3: {op, src1, src2, dest} = {OP_COPY,  R4, R0, R3};
            S_SORT4: {op, src1, src2, dest} = {OP_COPY,  R5, R0, R4};
            S_MUL1:  {op, src1, src2, dest} = {OP_MUL,   R1, R6, R10};
            S_ADD1:  {op, src1, src2, dest} = {OP_ADD,   R0, R10, R0};
            S_MUL2:  {op, src1, src2, dest} = {OP_MUL,   R2, R7, R10};
            S_SUB2:  {op, src1, src2, dest} = {OP_SUB,   R0, R10, R0};
            S_MUL3:  {op, src1, src2, dest} = {OP_MUL,   R3, R8, R10};
            S_ADD3:  {op, src1, src2, dest} = {OP_ADD,   R0, R10, R0};
            S_MUL4:  {op, src1, src2, dest} = {OP_MUL,   R4, R9, R10};
            S_SUB4:  {op, src1, src2, dest} = {OP_SUB,   R0, R10, R0};
            S_LOADC: {op, src1, src2, dest} = {OP_LOAD2, R0, R0, R6 + {2'b00, idx}};
            default: ;
        endcase
    end
endmodule
